// File: rtl/mant_mult_seq_pkg.sv
// Shared floating-point types and constants
// for the multiply front end and adder path.
package fp_pkg;

    localparam int BIAS = 127;
    localparam int MW   = 24;
    localparam int EW   = 8;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mant_mult_seq_if.sv
// Operand/result handshake bundle for the
// iterative significand multiplier.
interface mant_mult_seq_if #(
    parameter int MW = 24,
    parameter int EW = 8
);

    logic [31:0]     a;
    logic [31:0]     b;
    logic            in_valid;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic            sign;
    logic [EW+1:0]   exp_mult;
    logic [2*MW-1:0] P;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, out_valid,
        input  sign, exp_mult, P
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, out_valid,
        output sign, exp_mult, P
    );

endinterface

// File: rtl/mant_mult_seq_unpack.sv
// Splits a binary32 word into sign, exponent
// and significand with the hidden bit restored.
module fp_unpack
    import fp_pkg::*;
(
    input  fp32_t         op,
    output logic          sign,
    output logic [EW-1:0] exp,
    output logic [MW-1:0] sig
);

    // Exponent zero clears the hidden bit; no renormalisation
    always_comb begin
        sign = op.sign;
        exp  = op.exp;
        sig  = {|op.exp, op.man};
    end

endmodule

// File: rtl/mant_mult_seq.sv
// Radix-2 shift-add significand multiplier with
// sign and biased exponent, valid/ready on both sides.
module mant_mult_seq
    import fp_pkg::*;
#(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input logic           clk,
    input logic           rst,
    mant_mult_seq_if.slave bus
);

    localparam int PW = 2 * MW;
    localparam int XW = EW + 2;
    localparam int CW = $clog2(MW);

    mult_state_t state;
    mult_state_t state_n;

    logic [PW-1:0] mcand;
    logic [MW-1:0] mplier;
    logic [PW-1:0] acc;
    logic [PW-1:0] acc_n;
    logic [CW-1:0] cnt;

    logic          sign_q;
    logic [XW-1:0] exp_q;
    logic [PW-1:0] p_q;

    logic          sign_a;
    logic          sign_b;
    logic [EW-1:0] exp_a;
    logic [EW-1:0] exp_b;
    logic [MW-1:0] sig_a;
    logic [MW-1:0] sig_b;

    logic          accept;
    logic          last;

    fp_unpack u_unpack_a (
        .op   (fp32_t'(bus.a)),
        .sign (sign_a),
        .exp  (exp_a),
        .sig  (sig_a)
    );

    fp_unpack u_unpack_b (
        .op   (fp32_t'(bus.b)),
        .sign (sign_b),
        .exp  (exp_b),
        .sig  (sig_b)
    );

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.sign      = sign_q;
    assign bus.exp_mult  = exp_q;
    assign bus.P         = p_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (state == MULT) && (cnt == CW'(MW - 1));
    assign acc_n  = mplier[0] ? acc + mcand : acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: accept, iterate MW times, hold until consumed
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept)        state_n = MULT;
            MULT: if (last)          state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default:                 state_n = IDLE;
        endcase
    end

    // Shift-add datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            p_q    <= '0;
        end else if (accept) begin
            mcand  <= {{MW{1'b0}}, sig_a};
            mplier <= sig_b;
            acc    <= '0;
            cnt    <= '0;
            sign_q <= sign_a ^ sign_b;
            exp_q  <= XW'(exp_a) + XW'(exp_b)
                    - XW'(BIAS);
        end else if (state == MULT) begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) p_q <= acc_n;
        end
    end

endmodule

// File: doc/mant_mult_seq.md
# mant_mult_seq

Iterative single-precision multiply front end: it unpacks two IEEE-754 binary32 operands and computes the sign, the biased product exponent and the exact 48-bit significand product with a radix-2 shift-add datapath. It sits directly upstream of the normalize stage and supplies that stage's `exp_mult[9:0]` and `P[47:0]` inputs, plus the result sign. Transfers on both sides use a valid/ready handshake.

## Interface
- `MW`, default 24: significand width including the hidden bit. This sets the iteration count and the product width of 2·MW.
- `EW`, default 8: operand exponent field width. The output exponent width is EW+2.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `a`, `b`  in  32: binary32 operands, sampled on acceptance.
- `in_valid`  in  1: operands present.
- `in_ready`  out  1: block can accept. Equals (state==IDLE) && !rst.
- `out_valid`  out  1: result registers hold a completed product.
- `out_ready`  in  1: downstream consumes the result.
- `sign`  out  1: a[31]^b[31].
- `exp_mult`  out  10: expA+expB−127, two's-complement, wraps mod 2^10.
- `P`  out  48: {hA,mA}×{hB,mB}, exact.

## Operation
- **Unpack.**
  - Hidden bit h = |exp field. Exponent 0 yields h=0, so zero and subnormal operands are multiplied without renormalisation.
  - Inf and NaN are not special-cased here. Exception handling is downstream.
- **FSM states:** IDLE, MULT, DONE.
  - **IDLE:** on in_valid && in_ready:
    - latch multiplicand {hA,mA} zero-extended to 48 bits;
    - latch multiplier {hB,mB};
    - acc←0, cnt←0;
    - compute and latch sign and exp_mult;
    - go to MULT.
  - **MULT:** one iteration per cycle, for iterations i = 0..23:
    - if multiplier bit 0 is 1, acc += multiplicand;
    - multiplicand <<= 1;
    - multiplier >>= 1;
    - cnt++.
    - On the cycle with cnt==MW−1, after that final add, go to DONE with P←acc.
  - **DONE:**
    - out_valid=1.
    - sign, exp_mult and P are held stable until out_ready. Changes while out_valid=1 are a bug.
    - On out_ready, go to IDLE, same edge.
- **No overlap:** a new operand pair is not accepted while in MULT or DONE.
- **Exponent arithmetic:** {2'b0,expA}+{2'b0,expB}−10'd127 in 10 bits.
  - Overflow shows as values ≥255 (positive).
  - Underflow shows as bit 9 set (negative).
  - Classification is left to the normalize stage.
- **P[47] range:** P[47] is 1 only when the significand product is ≥2.0. For normal inputs P[47:46] is never 00.

## Timing
- **Reset values:** state=IDLE, out_valid=0, sign=0, exp_mult=0, P=0, acc=0, cnt=0.
  - in_ready=0 while rst is high, and 1 on the first cycle after.
- **Latency:** acceptance at edge N; out_valid is high after edge N+MW (N+24).
- **Throughput:** one result per MW+2 cycles minimum, with out_ready held high.
- **out_valid && out_ready** on edge M: out_valid falls and in_ready rises after M. The next acceptance is at M+1 at the earliest.
- **in_valid without in_ready:** ignored. Operands are not captured.
- **Reset mid-MULT or mid-DONE:** the partial product is discarded, all reset values apply on the next edge, and no out_valid pulse is produced.
- **in_valid and rst high on the same edge:** reset wins and nothing is accepted.

## Structure
- **Package `fp_pkg`:**
  - BIAS=127, MW, EW;
  - typedef `fp32_t` as a packed struct {sign, exp[7:0], man[22:0]};
  - enum `mult_state_t` {IDLE, MULT, DONE}.
- **Sub-module `fp_unpack`:** combinational. Takes `fp32_t` and returns sign, exponent and 24-bit significand with hidden bit. It is shared later by the adder path.
- **Top:** FSM, counter (5 bits), 48-bit accumulator/shift registers, output registers.

## Test plan
- **1.0 × 1.0:** a=b=0x3F800000 → after 24 cycles: P=0x4000_0000_0000, exp_mult=0x07F, sign=0.
- **1.5 × 1.5:** a=b=0x3FC00000 → P=0x9000_0000_0000 with P[47]=1, exp_mult=0x07F.
- **Sign:** a=0xC0000000 (−2.0), b=0x40400000 (3.0) → sign=1, exp_mult=0x081, P=0x6000_0000_0000.
- **Exponent boundaries:**
  - a=b=0x7F000000 → exp_mult=0x17D.
  - a=b=0x00800000 → exp_mult=0x383 (−125).
  - a=0x00000000 → P=0.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid → outputs constant, in_ready=0, in_valid pulses ignored. Then assert out_ready → in_ready=1 next cycle.
- **Reset mid-operation:** assert rst at cnt=10 → next cycle out_valid=0, P=0, in_ready=1 after release. A following 1.0×1.0 completes correctly.
